branch_pred_ctrl: RTL and testbench

- Controller and scheduler for a table of 2-bit saturating branch counters (pattern history table, PHT).
- Shares the table's single access slot between two requesters:
  - fetch-stage prediction lookups;
  - execute-stage branch-resolution updates, buffered in a small FIFO.
- Owns table initialisation after reset.
- Sits between fetch and execute in the pipeline.

---
 rtl/branch_pred_pkg.sv | 39 +++
 rtl/branch_upd_fifo.sv | 59 +++++
 rtl/branch_pred_ctrl.sv | 146 ++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// ============================================================================
//  branch_pred_pkg : shared types and constants for the branch predictor
//  Revision: 1.0
// ============================================================================
`default_nettype none

package branch_pred_pkg;

    localparam int CTR_W = 2;

    localparam logic [CTR_W-1:0] SNT = 2'b00;
    localparam logic [CTR_W-1:0] WNT = 2'b01;
    localparam logic [CTR_W-1:0] WT  = 2'b10;
    localparam logic [CTR_W-1:0] ST  = 2'b11;

    // Upper bound on the table index width carried in an update entry.
    localparam int MAX_IDX_W = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;

    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                  input logic             taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + CTR_W'(1);
        end
        return (ctr == SNT) ? SNT : ctr - CTR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_upd_fifo.sv
// ============================================================================
//  branch_upd_fifo : DEPTH-entry FIFO of resolved-branch updates with count
//  Revision: 1.0
// ============================================================================
`default_nettype none

module branch_upd_fifo
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push_i,
    input  upd_entry_t               push_data_i,
    input  logic                     pop_i,
    output upd_entry_t               pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    upd_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [PTR_W:0]     w_inc;
    logic [PTR_W:0]     w_dec;

    assign w_inc = {{PTR_W{1'b0}}, push_i};
    assign w_dec = {{PTR_W{1'b0}}, pop_i};

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + w_inc - w_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst && push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
// ============================================================================
//  branch_pred_ctrl : 2-bit counter PHT controller arbitrating lookups/updates
//  Optional gshare indexing: define BRANCH_PRED_GSHARE_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module branch_pred_ctrl
    import branch_pred_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    lk_valid,
    input  logic [PC_W-1:0]         lk_pc,
    output logic                    lk_ready,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic [IDX_W-1:0]        pred_idx,
    input  logic                    upd_valid,
    input  logic [PC_W-1:0]         upd_pc,
    input  logic                    upd_taken,
    output logic                    upd_ready,
    output logic [$clog2(DEPTH):0]  upd_count,
    output logic                    init_busy
);

    localparam int ENTRIES = 2**IDX_W;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    logic [CTR_W-1:0]   table_q [ENTRIES];
    logic               pred_valid_q, pred_taken_q;
    logic [IDX_W-1:0]   pred_idx_q;

    logic [IDX_W-1:0]   w_hist;
    logic [IDX_W-1:0]   w_lk_idx, w_upd_idx, w_head_idx, w_tbl_idx;
    logic [CTR_W-1:0]   w_tbl_wdata;
    logic               w_tbl_we, w_lk_fire, w_push, w_pop, w_full, w_empty;
    upd_entry_t         w_push_entry, w_head;
    logic               w_unused_bits;

`ifdef BRANCH_PRED_GSHARE_EN
    logic [IDX_W-1:0]   ghr_q;

    // History survives INIT; only rst clears it.
    always_ff @(posedge clock) begin
        if (rst)         ghr_q <= '0;
        else if (w_push) ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
    end
    assign w_hist = ghr_q;
`else
    assign w_hist = '0;
`endif

    assign w_lk_idx   = lk_pc[IDX_W+1:2] ^ w_hist;
    assign w_upd_idx  = upd_pc[IDX_W+1:2] ^ w_hist;
    assign w_head_idx = w_head.idx[IDX_W-1:0];
    assign w_push     = upd_valid && upd_ready;

    assign w_push_entry.idx   = MAX_IDX_W'(w_upd_idx);
    assign w_push_entry.taken = upd_taken;

    assign w_unused_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                             upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0],
                             w_head.idx[MAX_IDX_W-1:IDX_W]};

    branch_upd_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .count_o     (upd_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        lk_ready    = 1'b0;
        upd_ready   = 1'b0;
        init_busy   = 1'b0;
        w_lk_fire   = 1'b0;
        w_pop       = 1'b0;
        w_tbl_we    = 1'b0;
        w_tbl_idx   = init_ptr_q;
        w_tbl_wdata = SNT;
        case (state_q)
            INIT: begin
                init_busy  = 1'b1;
                w_tbl_we   = 1'b1;
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (&init_ptr_q) state_d = RUN;
            end
            RUN: begin
                lk_ready  = !w_full;
                upd_ready = !w_full;
                w_lk_fire = lk_valid && !w_full;
                // A full FIFO drains ahead of lookups so updates cannot starve.
                w_pop     = w_full || (!lk_valid && !w_empty);
                if (w_pop) begin
                    w_tbl_we    = 1'b1;
                    w_tbl_idx   = w_head_idx;
                    w_tbl_wdata = ctr_next(table_q[w_head_idx], w_head.taken);
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= INIT;
            init_ptr_q   <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            pred_valid_q <= w_lk_fire;
            if (w_lk_fire) begin
                pred_taken_q <= table_q[w_lk_idx][1];
                pred_idx_q   <= w_lk_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst && w_tbl_we) table_q[w_tbl_idx] <= w_tbl_wdata;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
// ============================================================================
//  tb_branch_pred_ctrl : directed + random bench with a behavioural PHT model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_pred_ctrl;

    localparam int PC_W    = 32;
    localparam int IDX_W   = 6;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 64;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              lk_valid = 1'b0;
    logic [PC_W-1:0]   lk_pc = '0;
    logic              lk_ready;
    logic              pred_valid, pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic [2:0]        upd_count;
    logic              init_busy;

    always #5 clock = ~clock;

    branch_pred_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .upd_count  (upd_count),
        .init_busy  (init_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_ctr [ENTRIES];
    int m_q_idx [$];
    bit m_q_tk  [$];
    int m_init_left = 0;
    int m_ghr = 0;
    bit m_pv = 0, m_pt = 0;
    int m_pi = 0;
    bit m_known = 0;
    bit m_after_rst = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        int base;
        base = int'((pc / 4) % ENTRIES);
`ifdef BRANCH_PRED_GSHARE_EN
        return base ^ m_ghr;
`else
        return base;
`endif
    endfunction

    task automatic model_edge();
        bit full, pop;
        int hidx;
        bit htk;
        if (rst) begin
            m_init_left = ENTRIES;
            m_q_idx.delete();
            m_q_tk.delete();
            m_pv = 0; m_pt = 0; m_pi = 0;
            m_ghr = 0;
            m_known = 1;
            m_after_rst = 1;
        end else if (m_init_left > 0) begin
            m_ctr[ENTRIES - m_init_left] = 0;
            m_init_left--;
            m_pv = 0;
            m_after_rst = 0;
        end else begin
            m_after_rst = 0;
            full = (m_q_idx.size() == DEPTH);
            pop  = full || (!lk_valid && m_q_idx.size() > 0);
            if (lk_valid && !full) begin
                m_pv = 1;
                m_pi = idx_of(lk_pc);
                m_pt = (m_ctr[m_pi] >= 2);
            end else begin
                m_pv = 0;
            end
            if (pop) begin
                hidx = m_q_idx.pop_front();
                htk  = m_q_tk.pop_front();
                m_ctr[hidx] = htk ? ((m_ctr[hidx] == 3) ? 3 : m_ctr[hidx] + 1)
                                  : ((m_ctr[hidx] == 0) ? 0 : m_ctr[hidx] - 1);
            end
            if (upd_valid && !full) begin
                m_q_idx.push_back(idx_of(upd_pc));
                m_q_tk.push_back(upd_taken);
                m_ghr = ((m_ghr * 2) + int'(upd_taken)) % ENTRIES;
            end
        end
    endtask

    task automatic cycle();
        bit run, full;
        @(negedge clock);
        if (m_known) begin
            run  = (m_init_left == 0);
            full = (m_q_idx.size() == DEPTH);
            check("lk_ready",  lk_ready,  run && !full);
            check("upd_ready", upd_ready, run && !full);
            check("init_busy", init_busy, !run);
            check("upd_count", upd_count, m_q_idx.size());
        end
        @(posedge clock);
        #1;
        model_edge();
        check("pred_valid", pred_valid, m_pv);
        if (m_pv || m_after_rst) begin
            check("pred_taken", pred_taken, m_pt);
            check("pred_idx",   pred_idx,   m_pi);
        end
    endtask

    task automatic run_init();
        int n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check("init_len", n, 64);
    endtask

    task automatic drain();
        lk_valid = 0; upd_valid = 0;
        repeat (DEPTH + 1) cycle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        lk_valid = 1; lk_pc = pc; upd_valid = 0;
        cycle();
        lk_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        // Reset with lookups held: INIT must refuse them for 64 cycles
        rst = 1; lk_valid = 1; lk_pc = 32'h40;
        cycle();
        rst = 0;
        run_init();
        cycle();
        check("first_lookup_idx", pred_idx, 16);
        check("first_lookup_tk",  pred_taken, 0);
        lk_valid = 0;

        // Saturation up
        upd_pc = 32'h40; upd_taken = 1;
        repeat (4) begin upd_valid = 1; cycle(); end
        drain();
`ifndef BRANCH_PRED_GSHARE_EN
        check("ctr16_sat_hi", dut.table_q[16], 3);
`endif
        lookup(32'h40);
        // Saturation down
        upd_pc = 32'h40; upd_taken = 0;
        repeat (5) begin upd_valid = 1; cycle(); end
        drain();
`ifndef BRANCH_PRED_GSHARE_EN
        check("ctr16_sat_lo", dut.table_q[16], 0);
`endif
        lookup(32'h40);

        // Full FIFO takes priority over a continuous lookup stream
        lk_valid = 1; lk_pc = 32'h80;
        upd_pc = 32'h44; upd_taken = 1;
        repeat (4) begin upd_valid = 1; cycle(); end
        check("full_count", upd_count, 4);
        upd_valid = 0;
        cycle();
        check("after_full_pop", upd_count, 3);
        drain();

        // Simultaneous push and pop at count 2, alternating outcomes
        lk_valid = 1; lk_pc = 32'h80;
        upd_pc = 32'h48; upd_taken = 1;
        repeat (2) begin upd_valid = 1; cycle(); end
        lk_valid = 0;
        for (int i = 0; i < 6; i++) begin
            upd_valid = 1; upd_taken = i[0];
            cycle();
            check("pushpop_count", upd_count, 2);
        end
        drain();
        lookup(32'h48);

        // Reset while FIFO holds 3 entries after training idx 16
        upd_pc = 32'h40; upd_taken = 1;
        repeat (3) begin upd_valid = 1; cycle(); end
        drain();
        lk_valid = 1; lk_pc = 32'h80;
        repeat (3) begin upd_valid = 1; cycle(); end
        upd_valid = 0; lk_valid = 0;
        rst = 1;
        cycle();
        rst = 0;
        check("rst_count", upd_count, 0);
        check("rst_pv",    pred_valid, 0);
        check("rst_init",  init_busy, 1);
        run_init();
        lookup(32'h40);
        check("reinit_tk", pred_taken, 0);

        // Random traffic over a handful of hot indices
        for (int i = 0; i < 400; i++) begin
            lk_valid  = ($urandom_range(0, 99) < 60);
            pc = $urandom; pc[7:2] = 6'($urandom_range(0, 3));
            lk_pc = pc;
            upd_valid = ($urandom_range(0, 99) < 50);
            pc = $urandom; pc[7:2] = 6'($urandom_range(0, 3));
            upd_pc = pc;
            upd_taken = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
